// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run / single-step / drain / done control for the PC and pipeline.
// Optional executed-cycle counter enabled by defining PC_SEQ_CYCLE_COUNTER_EN.
module pc_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_mode_run,
  input  logic                  i_step_req,
  input  logic                  i_clear,
  input  logic                  i_halt_detected,
  input  logic                  i_hazard_stall,
  input  logic                  i_branch_taken,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  output logic                  o_pc_stall,
  output logic                  o_pc_halt,
  output logic                  o_pc_jump,
  output logic [ADDR_WIDTH-1:0] o_pc_jump_address,
  output logic                  o_pipe_en,
  output logic                  o_done,
  output logic [2:0]            o_state,
  output logic [31:0]           o_cycle_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CYC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               step_prev_q;
  logic               advancing;
  logic               step_edge;

  assign advancing = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
  assign step_edge = i_step_req && !step_prev_q;

  // Next-state, drain counter and decoded outputs
  always_comb begin
    state_d           = state_q;
    drain_cnt_d       = drain_cnt_q;
    o_pc_halt         = !advancing;
    o_pipe_en         = advancing || (state_q == S_DRAIN);
    o_done            = (state_q == S_DONE);
    o_pc_stall        = i_hazard_stall && advancing;
    o_pc_jump         = i_branch_taken && advancing && !i_halt_detected;
    o_pc_jump_address = i_branch_target;
    o_state           = 3'(state_q);

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = i_mode_run ? S_RUN : S_STEP_WAIT;
      end
      S_RUN: begin
        if (i_halt_detected) begin
          state_d     = S_DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      S_STEP_WAIT: begin
        if (step_edge) state_d = S_STEP_EXEC;
      end
      S_STEP_EXEC: begin
        // Halt has priority; a stalled cycle keeps the step pending
        if (i_halt_detected) begin
          state_d     = S_DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end else if (!i_hazard_stall) begin
          state_d = S_STEP_WAIT;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_DONE;
        else                   drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        if (i_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      step_prev_q <= i_step_req;
    end
  end

`ifdef PC_SEQ_CYCLE_COUNTER_EN
  logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

  // Saturating count of pipeline-active cycles, cleared on launch
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == S_IDLE) && i_start) begin
      cycle_cnt_d = '0;
    end else if ((advancing || (state_q == S_DRAIN)) && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cycle_cnt_q <= '0;
    else            cycle_cnt_q <= cycle_cnt_d;
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized stimulus
// against a cycle-level behavioural model; honours PC_SEQ_CYCLE_COUNTER_EN.
module tb_pc_sequencer;

  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned ADDR_WIDTH   = 32;

  localparam int M_IDLE = 0, M_RUN = 1, M_SWAIT = 2, M_SEXEC = 3, M_DRAIN = 4, M_DONE = 5;

`ifdef PC_SEQ_CYCLE_COUNTER_EN
  localparam logic [31:0] EXP_RUN_COUNT = 32'd14;
`else
  localparam logic [31:0] EXP_RUN_COUNT = 32'd0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  i_start, i_mode_run, i_step_req, i_clear;
  logic                  i_halt_detected, i_hazard_stall, i_branch_taken;
  logic [ADDR_WIDTH-1:0] i_branch_target;
  logic                  o_pc_stall, o_pc_halt, o_pc_jump, o_pipe_en, o_done;
  logic [ADDR_WIDTH-1:0] o_pc_jump_address;
  logic [2:0]            o_state;
  logic [31:0]           o_cycle_count;

  pc_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_start           (i_start),
    .i_mode_run        (i_mode_run),
    .i_step_req        (i_step_req),
    .i_clear           (i_clear),
    .i_halt_detected   (i_halt_detected),
    .i_hazard_stall    (i_hazard_stall),
    .i_branch_taken    (i_branch_taken),
    .i_branch_target   (i_branch_target),
    .o_pc_stall        (o_pc_stall),
    .o_pc_halt         (o_pc_halt),
    .o_pc_jump         (o_pc_jump),
    .o_pc_jump_address (o_pc_jump_address),
    .o_pipe_en         (o_pipe_en),
    .o_done            (o_done),
    .o_state           (o_state),
    .o_cycle_count     (o_cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase, cycles left in drain, last step level, executed cycles
  int     m_state      = M_IDLE;
  int     m_drain_left = 0;
  logic   m_prev_step  = 1'b0;
  longint m_count      = 0;

  always @(posedge clk or negedge rst_n) begin
    int     nxt;
    int     left;
    longint cnt;
    if (!rst_n) begin
      m_state      <= M_IDLE;
      m_drain_left <= 0;
      m_prev_step  <= 1'b0;
      m_count      <= 0;
    end else begin
      nxt  = m_state;
      left = m_drain_left;
      cnt  = m_count;
      if ((m_state == M_RUN || m_state == M_SEXEC || m_state == M_DRAIN) && cnt < 64'hFFFF_FFFF)
        cnt = cnt + 1;
      case (m_state)
        M_IDLE:  if (i_start) begin cnt = 0; nxt = i_mode_run ? M_RUN : M_SWAIT; end
        M_RUN:   if (i_halt_detected) begin nxt = M_DRAIN; left = DRAIN_CYCLES; end
        M_SWAIT: if (i_step_req && !m_prev_step) nxt = M_SEXEC;
        M_SEXEC: begin
          if (i_halt_detected) begin nxt = M_DRAIN; left = DRAIN_CYCLES; end
          else if (!i_hazard_stall) nxt = M_SWAIT;
        end
        M_DRAIN: if (left <= 1) nxt = M_DONE; else left = left - 1;
        M_DONE:  if (i_clear) nxt = M_IDLE;
        default: nxt = M_IDLE;
      endcase
      m_state      <= nxt;
      m_drain_left <= left;
      m_prev_step  <= i_step_req;
      m_count      <= cnt;
    end
  end

  // Observation counters used by the directed scenarios
  int   halt0_cnt = 0;
  int   drain_obs = 0;
  logic done_seen = 1'b0;

  // Every-cycle compare, sampled well after inputs settle and before the next rising edge
  always @(negedge clk) begin
    logic adv;
    #4;
    adv = (m_state == M_RUN) || (m_state == M_SEXEC);
    chk("state",     32'(o_state),    32'(m_state));
    chk("pc_halt",   32'(o_pc_halt),  32'(!adv));
    chk("pipe_en",   32'(o_pipe_en),  32'(adv || m_state == M_DRAIN));
    chk("done",      32'(o_done),     32'(m_state == M_DONE));
    chk("pc_stall",  32'(o_pc_stall), 32'(i_hazard_stall && adv));
    chk("pc_jump",   32'(o_pc_jump),  32'(i_branch_taken && adv && !i_halt_detected));
    chk("jump_addr", o_pc_jump_address, i_branch_target);
`ifdef PC_SEQ_CYCLE_COUNTER_EN
    chk("cycle_cnt", o_cycle_count, 32'(m_count));
`else
    chk("cycle_cnt", o_cycle_count, 32'd0);
`endif
    if (!o_pc_halt) halt0_cnt++;
    if (o_state == 3'd4) drain_obs++;
    if (o_done) done_seen = 1'b1;
  end

  task automatic clear_inputs();
    i_start = 0; i_mode_run = 0; i_step_req = 0; i_clear = 0;
    i_halt_detected = 0; i_hazard_stall = 0; i_branch_taken = 0; i_branch_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    #4;
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_halt",  32'(o_pc_halt), 32'd1);
    chk("reset_count", o_cycle_count, 32'd0);

    // Continuous run, halt on 10th run cycle, four drain cycles
    do_reset();
    halt0_cnt = 0; drain_obs = 0;
    i_start = 1; i_mode_run = 1;
    @(negedge clk); i_start = 0;
    repeat (9) @(negedge clk);
    i_halt_detected = 1;
    @(negedge clk); i_halt_detected = 0;
    repeat (4) @(negedge clk);
    #4;
    chk("run_done",        32'(o_done), 32'd1);
    chk("run_adv_cycles",  32'(halt0_cnt), 32'd10);
    chk("run_drain_cycles",32'(drain_obs), 32'd4);
    chk("run_cycle_count", o_cycle_count, EXP_RUN_COUNT);

    // Single-step: three edges, each held five cycles
    do_reset();
    i_start = 1; i_mode_run = 0;
    @(negedge clk); i_start = 0;
    halt0_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      i_step_req = 1;
      repeat (5) @(negedge clk);
      i_step_req = 0;
      repeat (3) @(negedge clk);
    end
    #4;
    chk("step_adv_cycles", 32'(halt0_cnt), 32'd3);
    chk("step_wait_state", 32'(o_state), 32'd2);

    // Stalled step: two stalled cycles, then one advance
    @(negedge clk); i_step_req = 1;
    @(negedge clk); i_hazard_stall = 1;
    #4;
    chk("stall1_state", 32'(o_state), 32'd3);
    chk("stall1_out",   32'(o_pc_stall), 32'd1);
    @(negedge clk); #4;
    chk("stall2_state", 32'(o_state), 32'd3);
    chk("stall2_out",   32'(o_pc_stall), 32'd1);
    @(negedge clk); i_hazard_stall = 0; #4;
    chk("unstall_state", 32'(o_state), 32'd3);
    chk("unstall_halt",  32'(o_pc_halt), 32'd0);
    @(negedge clk); #4;
    chk("stepback_state", 32'(o_state), 32'd2);
    @(negedge clk); i_step_req = 0;

    // Branch in run, then branch with halt
    do_reset();
    i_start = 1; i_mode_run = 1;
    @(negedge clk); i_start = 0;
    i_branch_taken = 1; i_branch_target = 32'h0000_0040;
    #4;
    chk("jump_taken", 32'(o_pc_jump), 32'd1);
    chk("jump_target", o_pc_jump_address, 32'h0000_0040);
    @(negedge clk); i_halt_detected = 1; #4;
    chk("jump_suppressed", 32'(o_pc_jump), 32'd0);
    @(negedge clk); i_halt_detected = 0; i_branch_taken = 0; #4;
    chk("halt_to_drain", 32'(o_state), 32'd4);

    // Reset mid-drain aborts the operation
    @(negedge clk);
    rst_n = 1'b0; #4;
    chk("abort_state", 32'(o_state), 32'd0);
    chk("abort_halt",  32'(o_pc_halt), 32'd1);
    done_seen = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_idle",    32'(o_state), 32'd0);

    // DONE ignores start, leaves on clear
    do_reset();
    i_start = 1; i_mode_run = 1;
    @(negedge clk); i_start = 0; i_halt_detected = 1;
    @(negedge clk); i_halt_detected = 0;
    repeat (4) @(negedge clk);
    i_start = 1;
    @(negedge clk);
    @(negedge clk); #4;
    chk("done_hold_state", 32'(o_state), 32'd5);
    chk("done_hold_flag",  32'(o_done), 32'd1);
    @(negedge clk); i_start = 0; i_clear = 1;
    @(negedge clk); i_clear = 0; #4;
    chk("clear_to_idle", 32'(o_state), 32'd0);

    // Randomized traffic checked cycle-by-cycle by the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      i_start         = ($urandom_range(0, 7) == 0);
      i_mode_run      = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0) i_step_req = ~i_step_req;
      i_clear         = ($urandom_range(0, 9) == 0);
      i_halt_detected = ($urandom_range(0, 24) == 0);
      i_hazard_stall  = ($urandom_range(0, 3) == 0);
      i_branch_taken  = ($urandom_range(0, 2) == 0);
      i_branch_target = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    #6;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
